// File: rtl/tgbase64_to_ascii7b_stream_pkg.sv
// ---------------------------------------------------------------------------
// tgbase64_pkg : shared types, range constants and code-to-ASCII decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tgbase64_pkg;

  typedef logic [5:0] code_t;
  typedef logic [6:0] ascii_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  localparam code_t  CODE_DIGIT_LO = 6'd2;
  localparam code_t  CODE_UPPER_LO = 6'd12;
  localparam code_t  CODE_LOWER_LO = 6'd38;

  localparam ascii_t OFFS_SPACE = 7'd32;
  localparam ascii_t OFFS_DIGIT = 7'd46;
  localparam ascii_t OFFS_UPPER = 7'd53;
  localparam ascii_t OFFS_LOWER = 7'd59;

  // Every code is legal: 0/1 map to space and '!', then digits, upper, lower.
  function automatic ascii_t decode_code(input code_t c);
    ascii_t c7;
    c7 = {1'b0, c};
    if (c < CODE_DIGIT_LO)      return c7 + OFFS_SPACE;
    else if (c < CODE_UPPER_LO) return c7 + OFFS_DIGIT;
    else if (c < CODE_LOWER_LO) return c7 + OFFS_UPPER;
    else                        return c7 + OFFS_LOWER;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tgbase64_to_ascii7b_stream_if.sv
// ---------------------------------------------------------------------------
// tgbase64_to_ascii7b_stream_if : input word stream and output char stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tgbase64_to_ascii7b_stream_if;
  import tgbase64_pkg::*;

  logic [23:0] s_data;
  logic [1:0]  s_nsym;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;

  ascii_t      m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  // Slave is the decoder's view; master is the surrounding environment.
  modport slave (
    input  s_data, s_nsym, s_last, s_valid, m_ready,
    output s_ready, m_data, m_last, m_valid
  );

  modport master (
    output s_data, s_nsym, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_valid
  );

endinterface

`default_nettype wire

// File: rtl/tgbase64_to_ascii7b_stream_char_decode.sv
// ---------------------------------------------------------------------------
// tgbase64_char_decode : combinational 6-bit tgBASE code to 7-bit ASCII
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tgbase64_char_decode
  import tgbase64_pkg::*;
(
  input  code_t  code_i,
  output ascii_t ascii_o
);

  assign ascii_o = decode_code(code_i);

endmodule

`default_nettype wire

// File: rtl/tgbase64_to_ascii7b_stream.sv
// ---------------------------------------------------------------------------
// tgbase64_to_ascii7b_stream : unpacks 4-code words into one ASCII char/cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tgbase64_to_ascii7b_stream
  import tgbase64_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  tgbase64_to_ascii7b_stream_if.slave   bus,
  output logic [7:0]                    char_cnt
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q,   idx_d;
  logic [23:0] word_q,  word_d;
  logic [1:0]  nsym_q,  nsym_d;
  logic        last_q,  last_d;
  logic [7:0]  cnt_q,   cnt_d;

  logic        w_at_last;
  logic        w_s_ready;
  logic        w_m_valid;
  logic        w_m_last;
  logic        w_in_hs;
  logic        w_out_hs;
  code_t       w_sym;
  ascii_t      w_ascii;

  // Handshake qualifiers; s_ready only opens in EMIT once the final symbol leaves.
  always_comb begin
    w_at_last = (idx_q == nsym_q);
    w_m_valid = (state_q == ST_EMIT);
    w_m_last  = w_m_valid && last_q && w_at_last;
    w_s_ready = !rst && ((state_q == ST_EMPTY) || (w_at_last && bus.m_ready));
    w_in_hs   = bus.s_valid && w_s_ready;
    w_out_hs  = w_m_valid && bus.m_ready;
  end

  always_comb begin
    w_sym = word_q[23:18];
    case (idx_q)
      2'd0:    w_sym = word_q[23:18];
      2'd1:    w_sym = word_q[17:12];
      2'd2:    w_sym = word_q[11:6];
      default: w_sym = word_q[5:0];
    endcase
  end

  tgbase64_char_decode u_decode (
    .code_i  (w_sym),
    .ascii_o (w_ascii)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    nsym_d  = nsym_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    // An input handshake in EMIT implies the final symbol is leaving this cycle.
    if (w_in_hs) begin
      word_d  = bus.s_data;
      nsym_d  = bus.s_nsym;
      last_d  = bus.s_last;
      idx_d   = 2'd0;
      state_d = ST_EMIT;
    end else if (w_out_hs) begin
      if (w_at_last) state_d = ST_EMPTY;
      else           idx_d   = idx_q + 2'd1;
    end

    if (w_out_hs) begin
      cnt_d = w_m_last ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= 2'd0;
      word_q  <= 24'd0;
      nsym_q  <= 2'd0;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      nsym_q  <= nsym_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_last  = w_m_last;
  assign bus.m_data  = w_ascii;
  assign char_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: doc/tgbase64_to_ascii7b_stream.md
TGBASE64_TO_ASCII7B_STREAM -- requirements
Module: tgbase64_to_ascii7b_stream

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port s_data, input, 24 bits: four packed 6-bit tgBASE codes; symbol 0 = [23:18], symbol 1 = [17:12], symbol 2 = [11:6], symbol 3 = [5:0].
REQ-004 SHALL have port s_nsym, input, 2 bits: number of valid symbols in word minus one (0 -> 1 symbol, 3 -> 4 symbols); valid symbols are always the leading ones.
REQ-005 SHALL have port s_last, input, 1 bit: word ends the message.
REQ-006 SHALL have port s_valid, input, 1 bit: input word offered.
REQ-007 SHALL have port s_ready, output, 1 bit: block accepts word this cycle.
REQ-008 SHALL have port m_data, output, 7 bits: decoded ASCII character.
REQ-009 SHALL have port m_last, output, 1 bit: character is the final one of the message.
REQ-010 SHALL have port m_valid, output, 1 bit: m_data/m_last valid.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts character.
REQ-012 SHALL have port char_cnt, output, 8 bits: characters emitted in the current message.

Function
REQ-013 SHALL decode each code c as: 0 -> 32, 1 -> 33, 2..11 -> c+46 ('0'..'9'), 12..37 -> c+53 ('A'..'Z'), 38..63 -> c+59 ('a'..'z'); all 64 codes are legal.
REQ-014 SHALL transfer input only when s_valid and s_ready are both high, and output only when m_valid and m_ready are both high.
REQ-015 SHALL implement states EMPTY and EMIT, plus a 2-bit symbol index idx and a held word, nsym and last.
REQ-016 In EMPTY: s_ready=1, m_valid=0; on input handshake SHALL latch word/nsym/last, set idx=0 and go to EMIT.
REQ-017 In EMIT: m_valid=1, m_data=decode(symbol idx), m_last=held_last and (idx==held_nsym).
REQ-018 In EMIT, on output handshake with idx<held_nsym: SHALL increment idx.
REQ-019 In EMIT, on output handshake with idx==held_nsym: SHALL go to EMPTY, unless a new word is accepted in the same cycle, in which case SHALL stay in EMIT with idx=0 and the new word.
REQ-020 s_ready SHALL be 1 in EMPTY, and in EMIT only when idx==held_nsym and m_ready=1; otherwise 0.
REQ-021 Latency: a word accepted in cycle N SHALL present symbol 0 on m_data in cycle N+1.
REQ-022 Sustained throughput SHALL be one character per cycle across word boundaries when s_valid and m_ready are held high.
REQ-023 While m_valid=1 and m_ready=0: m_data, m_last and idx SHALL hold stable.
REQ-024 char_cnt SHALL increment by 1 on each output handshake, wrap 255 -> 0, and clear to 0 on the handshake carrying m_last=1.
REQ-025 All outputs SHALL be driven from registers or from decoding of registered state only; no combinational path from s_data to m_data.

Reset
REQ-026 rst=1 at a clock edge SHALL force EMPTY, idx=0, held word/nsym/last=0 and char_cnt=0; m_valid=0, m_last=0, m_data=32 (decode of 0).
REQ-027 Reset mid-message SHALL discard any held word and unsent characters; the first word after reset starts a new message.
REQ-028 s_ready SHALL be 0 while rst=1 and SHALL be 1 in the cycle after rst is released.

Structure
REQ-029 A shared package tgbase64_pkg SHALL hold the 6-bit code and 7-bit ASCII typedefs, the range constants (2, 12, 38 and offsets 46/53/59), and the code-to-ASCII decode function.
REQ-030 A combinational sub-module tgbase64_char_decode (6-bit in, 7-bit out) SHALL implement REQ-013 and be instantiated once, on the selected symbol.

Verification
REQ-031 Word {12,38,2,0} ('A','a','0',' '), nsym=3, last=1, m_ready=1 -> m_data 65,97,48,32 on four consecutive cycles; m_last only on 32; char_cnt then 0.
REQ-032 Exhaustive sweep of codes 0..63 -> outputs match REQ-013, including boundaries 1->33, 11->57, 37->90, 63->122.
REQ-033 Two back-to-back 4-symbol words, s_valid and m_ready held high -> eight characters in eight consecutive cycles, s_ready pulses on the 4th character.
REQ-034 Word with nsym=1 ({13,39,x,x}) and last=1 -> only 'B','b' emitted; m_last on 'b'.
REQ-035 m_ready toggled pseudo-randomly -> no character dropped or duplicated, and m_data stable while stalled.
REQ-036 rst asserted after 2 of 4 characters -> m_valid=0 and char_cnt=0 next cycle; the next word decodes from symbol 0.
